// File: rtl/sort4_sequencer_pkg.sv
// Shared definitions for the sort4_sequencer block: FSM encodings, default sizes
// and the total-compare helper. The optional early-exit feature is SORT_EARLY_EXIT_EN.
package sort4_sequencer_pkg;

   localparam int DEFAULT_N_ELEMS = 4;
   localparam int DEFAULT_WIDTH   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int total_cmps(input int n);
      return (n * (n - 1)) / 2;
   endfunction

   localparam int DEFAULT_TOTAL_CMPS = total_cmps(DEFAULT_N_ELEMS);

endpackage

// File: rtl/sort_cas_cell.sv
// Combinational signed compare-and-swap: lo/hi are the ordered pair, swap flags a > b.
module sort_cas_cell #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             swap
);

   assign swap = $signed(a) > $signed(b);
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;

endmodule

// File: rtl/sort4_sequencer.sv
// Sequential in-place bubble sorter using one time-multiplexed compare-and-swap cell.
// Define SORT_EARLY_EXIT_EN to finish as soon as a full pass makes no swap.
module sort4_sequencer
   import sort4_sequencer_pkg::*;
#(
   parameter int N_ELEMS = DEFAULT_N_ELEMS,
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int CNT_W   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [N_ELEMS*WIDTH-1:0] sorted_flat,
   output logic [CNT_W-1:0]         swap_count
);

   localparam int PTR_W = $clog2(N_ELEMS);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   elem_reg  [N_ELEMS];
   logic [WIDTH-1:0]   elem_next [N_ELEMS];
   logic [PTR_W-1:0]   load_ptr_reg, load_ptr_next;
   logic [PTR_W-1:0]   pass_reg, pass_next;
   logic [PTR_W-1:0]   cmp_reg, cmp_next;
   logic [PTR_W-1:0]   cmp_hi_idx;
   logic [CNT_W-1:0]   swap_count_reg, swap_count_next;
   logic [WIDTH-1:0]   cas_lo, cas_hi;
   logic               cas_swap;
   logic               last_cmp, last_pass;
`ifdef SORT_EARLY_EXIT_EN
   logic               pass_swapped_reg, pass_swapped_next;
`endif

   assign cmp_hi_idx = cmp_reg + PTR_W'(1);
   assign last_cmp   = (cmp_reg == PTR_W'(N_ELEMS - 2) - pass_reg);
   assign last_pass  = (pass_reg == PTR_W'(N_ELEMS - 2));

   sort_cas_cell #(
      .WIDTH (WIDTH)
   ) u_cas (
      .a    (elem_reg[cmp_reg]),
      .b    (elem_reg[cmp_hi_idx]),
      .lo   (cas_lo),
      .hi   (cas_hi),
      .swap (cas_swap)
   );

   always_comb begin
      state_next      = state_reg;
      load_ptr_next   = load_ptr_reg;
      pass_next       = pass_reg;
      cmp_next        = cmp_reg;
      swap_count_next = swap_count_reg;
      for (int i = 0; i < N_ELEMS; i++) begin
         elem_next[i] = elem_reg[i];
      end
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped_next = pass_swapped_reg;
`endif

      unique case (state_reg)
         IDLE: begin
            // A load wins over a same-cycle start.
            if (load_valid) begin
               elem_next[load_ptr_reg] = load_data;
               load_ptr_next = (load_ptr_reg == PTR_W'(N_ELEMS - 1)) ? '0
                                                                       : load_ptr_reg + PTR_W'(1);
            end else if (start) begin
               state_next      = SORT;
               swap_count_next = '0;
               pass_next       = '0;
               cmp_next        = '0;
`ifdef SORT_EARLY_EXIT_EN
               pass_swapped_next = 1'b0;
`endif
            end
         end

         SORT: begin
            if (cas_swap) begin
               elem_next[cmp_reg]    = cas_lo;
               elem_next[cmp_hi_idx] = cas_hi;
               swap_count_next       = swap_count_reg + CNT_W'(1);
            end
            if (last_cmp) begin
               cmp_next = '0;
               if (last_pass) begin
                  state_next = DONE;
               end else begin
                  pass_next = pass_reg + PTR_W'(1);
               end
`ifdef SORT_EARLY_EXIT_EN
               pass_swapped_next = 1'b0;
               if (!(pass_swapped_reg || cas_swap)) begin
                  state_next = DONE;
               end
`endif
            end else begin
               cmp_next = cmp_reg + PTR_W'(1);
`ifdef SORT_EARLY_EXIT_EN
               pass_swapped_next = pass_swapped_reg | cas_swap;
`endif
            end
         end

         DONE: begin
            load_ptr_next = '0;
            state_next    = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         load_ptr_reg   <= '0;
         pass_reg       <= '0;
         cmp_reg        <= '0;
         swap_count_reg <= '0;
`ifdef SORT_EARLY_EXIT_EN
         pass_swapped_reg <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         load_ptr_reg   <= load_ptr_next;
         pass_reg       <= pass_next;
         cmp_reg        <= cmp_next;
         swap_count_reg <= swap_count_next;
`ifdef SORT_EARLY_EXIT_EN
         pass_swapped_reg <= pass_swapped_next;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < N_ELEMS; gi++) begin : g_elem
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               elem_reg[gi] <= '0;
            end else begin
               elem_reg[gi] <= elem_next[gi];
            end
         end
         assign sorted_flat[gi*WIDTH +: WIDTH] = elem_reg[gi];
      end
   endgenerate

   assign busy       = (state_reg == SORT);
   assign done       = (state_reg == DONE);
   assign swap_count = swap_count_reg;

endmodule

// File: tb/tb_sort4_sequencer.sv
// Self-checking bench for sort4_sequencer: vector table, bubble-sort reference model
// and a scoreboard queue, plus hand-written reset and ignored-input sequences.
module tb_sort4_sequencer;

   logic        clk;
   logic        reset;
   logic        load_valid;
   logic [3:0]  load_data;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] sorted_flat;
   logic [2:0]  swap_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] loads;
      logic [15:0] exp_flat;
      int          exp_swaps;
   } vec_t;

   typedef struct {
      logic [15:0] flat;
      int          swaps;
      int          lat;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[5];

   sort4_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .sorted_flat (sorted_flat),
      .swap_count  (swap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference bubble sort; returns result, swap count and number of compares.
   function automatic void model(input logic [15:0] ld, output logic [15:0] res,
                                 output int sw, output int ncmp);
      logic signed [3:0] e[4];
      logic signed [3:0] t;
      bit any;
      bit stop;
      sw = 0;
      ncmp = 0;
      stop = 0;
      for (int i = 0; i < 4; i++) e[i] = ld[i*4 +: 4];
      for (int p = 0; p < 3; p++) begin
         if (!stop) begin
            any = 0;
            for (int c = 0; c < 3 - p; c++) begin
               ncmp++;
               if (e[c] > e[c+1]) begin
                  t = e[c]; e[c] = e[c+1]; e[c+1] = t;
                  sw++;
                  any = 1;
               end
            end
`ifdef SORT_EARLY_EXIT_EN
            if (!any) stop = 1;
`endif
         end
      end
      for (int i = 0; i < 4; i++) res[i*4 +: 4] = e[i];
   endfunction

   task automatic load_elem(input logic [3:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
      load_data  = 4'd0;
   endtask

   task automatic run_sort(input logic [15:0] ld, input bit inject, input string tag);
      sb_t exp;
      sb_t got;
      int  cyc;
      int  busy_cycles;
      for (int i = 0; i < 4; i++) load_elem(ld[i*4 +: 4]);
      model(ld, exp.flat, exp.swaps, exp.lat);
      exp.lat = exp.lat + 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      sb_q.push_back(exp);
      cyc = 1;
      busy_cycles = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cycles++;
         if (inject && cyc == 2) begin
            start      = 1'b1;
            load_valid = 1'b1;
            load_data  = 4'd5;
         end
         tick();
         start      = 1'b0;
         load_valid = 1'b0;
         load_data  = 4'd0;
         cyc++;
      end
      check({tag, " done_seen"}, {31'd0, done}, 32'd1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         check({tag, " sorted_flat"}, {16'd0, sorted_flat}, {16'd0, got.flat});
         check({tag, " swap_count"}, {29'd0, swap_count}, got.swaps);
         check({tag, " latency"}, cyc, got.lat);
         check({tag, " busy_cycles"}, busy_cycles, got.lat - 1);
      end
      $display("sort %s: loads=%h flat=%h swaps=%0d done_after=%0d busy=%0d",
               tag, ld, sorted_flat, swap_count, cyc, busy_cycles);
      tick();
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int idle_busy;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = 4'd0;
      start      = 1'b0;

      // Element i lives at bits [i*4 +: 4]; loads are applied element0 first.
      vecs[0] = '{16'h87E3, 16'h73E8, 4};   // 3,-2,7,-8
      vecs[1] = '{16'h4321, 16'h4321, 0};   // 1,2,3,4
      vecs[2] = '{16'h8F07, 16'h70F8, 6};   // 7,0,-1,-8
      vecs[3] = '{16'hDDDD, 16'hDDDD, 0};   // all -3
      vecs[4] = '{16'h078F, 16'h70F8, 2};   // -1,-8,7,0

      #2 reset = 1'b1;
      #2;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset swap_count", {29'd0, swap_count}, 32'd0);
      check("reset sorted_flat", {16'd0, sorted_flat}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         logic [15:0] mres;
         int msw;
         int mcmp;
         model(vecs[v].loads, mres, msw, mcmp);
         check($sformatf("vec%0d model_flat", v), {16'd0, mres}, {16'd0, vecs[v].exp_flat});
         check($sformatf("vec%0d model_swaps", v), msw, vecs[v].exp_swaps);
         run_sort(vecs[v].loads, 1'b0, $sformatf("vec%0d", v));
         check($sformatf("vec%0d table_flat", v), {16'd0, sorted_flat}, {16'd0, vecs[v].exp_flat});
         check($sformatf("vec%0d table_swaps", v), {29'd0, swap_count}, vecs[v].exp_swaps);
      end

      // Asynchronous reset in the middle of a sort.
      for (int i = 0; i < 4; i++) load_elem(vecs[0].loads[i*4 +: 4]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midsort reset busy", {31'd0, busy}, 32'd0);
      check("midsort reset done", {31'd0, done}, 32'd0);
      check("midsort reset swap_count", {29'd0, swap_count}, 32'd0);
      check("midsort reset sorted_flat", {16'd0, sorted_flat}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      load_elem(4'd5);
      check("post reset load_ptr0", {16'd0, sorted_flat}, 32'h0005);
      check("post reset idle", {31'd0, busy}, 32'd0);
      $display("reset mid-sort: flat after one load=%h", sorted_flat);

      // start/load_valid during SORT are ignored.
      pulse_reset();
      run_sort(vecs[0].loads, 1'b1, "ignore_in_sort");

      // Same-cycle load+start in IDLE: load lands at element0, no sort.
      load_valid = 1'b1;
      load_data  = 4'd5;
      start      = 1'b1;
      tick();
      load_valid = 1'b0;
      load_data  = 4'd0;
      start      = 1'b0;
      idle_busy = 0;
      for (int c = 0; c < 8; c++) begin
         if (busy || done) idle_busy++;
         tick();
      end
      check("load_start no sort", idle_busy, 0);
      check("load_start flat", {16'd0, sorted_flat}, 32'h73E5);
      check("load_start swap_count kept", {29'd0, swap_count}, 32'd4);
      $display("load+start: flat=%h swaps=%0d", sorted_flat, swap_count);

      check("scoreboard drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
